// File: rtl/dds_stat.sv
// DDS sample-statistics engine: tracks min, max and count of the unsigned sample
// stream over a programmable window and publishes the results for register readback.
module dds_stat #(
    parameter int SAMPLE_W = 8,
    parameter int COUNT_W  = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [1:0]          stat_cfg,
    input  logic [COUNT_W-1:0]  stat_limit,
    output logic [SAMPLE_W-1:0] stat_min,
    output logic [SAMPLE_W-1:0] stat_max,
    output logic [COUNT_W-1:0]  stat_count,
    output logic                stat_done
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [SAMPLE_W-1:0] MIN_INIT   = {SAMPLE_W{1'b1}};
    localparam logic [SAMPLE_W-1:0] MAX_INIT   = {SAMPLE_W{1'b0}};
    localparam logic [COUNT_W-1:0]  COUNT_INIT = {COUNT_W{1'b0}};

    function automatic logic [SAMPLE_W-1:0] umin(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [SAMPLE_W-1:0] umax(input logic [SAMPLE_W-1:0] a,
                                                 input logic [SAMPLE_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    state_t               state_q, state_d;
    logic [SAMPLE_W-1:0]  w_min_q, w_min_d;
    logic [SAMPLE_W-1:0]  w_max_q, w_max_d;
    logic [COUNT_W-1:0]   w_count_q, w_count_d;
    logic [SAMPLE_W-1:0]  p_min_q, p_min_d;
    logic [SAMPLE_W-1:0]  p_max_q, p_max_d;
    logic [COUNT_W-1:0]   p_count_q, p_count_d;
    logic                 done_q, done_d;

    logic [SAMPLE_W-1:0]  n_min_s;
    logic [SAMPLE_W-1:0]  n_max_s;
    logic [COUNT_W-1:0]   n_count_s;
    logic [COUNT_W:0]     count_inc_s;
    logic                 win_end_s;

    // Candidate statistics if the current sample is accepted; the extra count bit
    // keeps the window-end compare exact even when the counter is saturated.
    always_comb begin
        n_min_s     = umin(w_min_q, sample);
        n_max_s     = umax(w_max_q, sample);
        count_inc_s = {1'b0, w_count_q} + {{COUNT_W{1'b0}}, 1'b1};
        if (count_inc_s[COUNT_W]) begin
            n_count_s = w_count_q;
        end else begin
            n_count_s = count_inc_s[COUNT_W-1:0];
        end
        win_end_s = (stat_limit != COUNT_INIT) && (count_inc_s >= {1'b0, stat_limit});
    end

    // Next-state and register update logic; clear overrides everything else.
    always_comb begin
        state_d   = state_q;
        w_min_d   = w_min_q;
        w_max_d   = w_max_q;
        w_count_d = w_count_q;
        p_min_d   = p_min_q;
        p_max_d   = p_max_q;
        p_count_d = p_count_q;
        done_d    = 1'b0;

        if (stat_cfg[0]) begin
            state_d   = ST_CLEAR;
            w_min_d   = MIN_INIT;
            w_max_d   = MAX_INIT;
            w_count_d = COUNT_INIT;
            p_min_d   = MIN_INIT;
            p_max_d   = MAX_INIT;
            p_count_d = COUNT_INIT;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (sample_valid) begin
                        w_min_d   = n_min_s;
                        w_max_d   = n_max_s;
                        w_count_d = n_count_s;
                        if (stat_limit == COUNT_INIT) begin
                            p_min_d   = n_min_s;
                            p_max_d   = n_max_s;
                            p_count_d = n_count_s;
                        end else if (win_end_s) begin
                            p_min_d   = n_min_s;
                            p_max_d   = n_max_s;
                            p_count_d = n_count_s;
                            done_d    = 1'b1;
                            // Continuous mode restarts the window on the same edge.
                            if (stat_cfg[1]) begin
                                w_min_d   = MIN_INIT;
                                w_max_d   = MAX_INIT;
                                w_count_d = COUNT_INIT;
                            end else begin
                                state_d = ST_DONE;
                            end
                        end else begin
                            done_d = 1'b0;
                        end
                    end else begin
                        done_d = 1'b0;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_CLEAR;
                end
            endcase
        end
    end

    // State and statistics registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_CLEAR;
            w_min_q   <= MIN_INIT;
            w_max_q   <= MAX_INIT;
            w_count_q <= COUNT_INIT;
            p_min_q   <= MIN_INIT;
            p_max_q   <= MAX_INIT;
            p_count_q <= COUNT_INIT;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            w_min_q   <= w_min_d;
            w_max_q   <= w_max_d;
            w_count_q <= w_count_d;
            p_min_q   <= p_min_d;
            p_max_q   <= p_max_d;
            p_count_q <= p_count_d;
            done_q    <= done_d;
        end
    end

    assign stat_min   = p_min_q;
    assign stat_max   = p_max_q;
    assign stat_count = p_count_q;
    assign stat_done  = done_q;

endmodule

// File: doc/dds_stat.md
# dds_stat

Sample-statistics engine that sits directly downstream of the DDS output mux, alongside the DAC path. It observes the 8-bit unsigned DDS sample stream and measures min, max and sample count over a window whose length and mode come from the DDS register block. Its results are presented back to the register block for APB readback. It runs entirely in the DDS clock domain.

## Interface
Parameters:
- SAMPLE_W, 8, sample width, unsigned
- COUNT_W, 32, counter and limit width

Ports:
- clk  in  1  DDS clock
- reset  in  1  synchronous, active-high
- sample_valid  in  1  qualifies sample; one sample per asserted cycle
- sample  in  SAMPLE_W  unsigned DDS output code
- stat_cfg  in  2  bit0 = clear (held clear while 1); bit1 = continuous mode (0 = single-shot)
- stat_limit  in  COUNT_W  window length in samples; 0 = unbounded
- stat_min  out  SAMPLE_W  published minimum
- stat_max  out  SAMPLE_W  published maximum
- stat_count  out  COUNT_W  published sample count
- stat_done  out  1  one-cycle pulse per completed window

## Operation
- Internal working registers: w_min, w_max, w_count. Published registers drive stat_min, stat_max and stat_count.
- State machine:
  - CLEAR to RUN when stat_cfg[0]=0.
  - RUN to DONE at window end in single-shot mode.
  - DONE to CLEAR when stat_cfg[0]=1.
  - From any state, stat_cfg[0]=1 forces CLEAR.
- CLEAR:
  - Working and published registers are held at min=all-ones, max=0, count=0.
  - Samples are ignored.
- RUN, on each cycle with sample_valid:
  - n_min = min(w_min, sample), n_max = max(w_max, sample).
  - n_count = w_count+1, saturating at all-ones.
  - Working registers take the n_* values.
- Window end: a valid sample in RUN with stat_limit≠0 and w_count+1 ≥ stat_limit.
  - The ≥ comparison covers stat_limit being lowered mid-window.
  - Published registers take n_min, n_max and n_count.
  - stat_done pulses for one cycle.
  - Continuous mode: working registers reinitialise (all-ones, 0, 0) on the same edge, so the next valid sample starts a new window. No sample is lost.
  - Single-shot mode: enter DONE. Published values are held and all samples are ignored until a clear.
- Unbounded mode (stat_limit=0):
  - Published registers take the n_* values on every valid sample (live tracking).
  - stat_done never pulses.
  - Count saturates at all-ones.
- stat_cfg[1] is sampled at window end. Changing it mid-window affects only the current window's termination.
- Comparisons are unsigned.

## Timing
- Reset values:
  - stat_min = all-ones, stat_max = 0, stat_count = 0, stat_done = 0.
  - State = CLEAR; working registers match the published values.
- Latency:
  - A valid sample on edge N is reflected in the working registers after edge N.
  - Published outputs update after edge N only at window end or in unbounded mode.
  - stat_done is high in the cycle after the edge that latched the window end.
- Clear latency: stat_cfg[0] rising at edge N forces all registers to clear values after edge N.
- Precedence:
  - Clear wins over a simultaneous valid sample and over a simultaneous window end. The sample is dropped and stat_done does not pulse.
- Reset mid-window returns everything to reset values on the next edge.
- Because stat_cfg resets to 1 in the register block, the engine stays in CLEAR after system reset until software writes bit0=0.
- stat_limit=1 gives a window end on every valid sample.
- Back-to-back sample_valid every cycle is supported with no stall.

## Test plan
- Single-shot, limit=4:
  - Stimulus: cfg=0b00, samples 0x40, 0x10, 0xF0, 0x80.
  - Required: stat_min=0x10, stat_max=0xF0, stat_count=4, one stat_done pulse.
  - Then feed a further sample 0x00: outputs unchanged and no pulse.
- Continuous, limit=3:
  - Stimulus: cfg=0b10, samples 1,2,3,9,8,7 on consecutive cycles.
  - Required: first window min=1, max=3, count=3; second window min=7, max=9, count=3; two stat_done pulses, three cycles apart.
- Unbounded, limit=0:
  - Stimulus: samples 0x55 then 0xAA.
  - Required: the outputs update one cycle after each sample, ending at min=0x55, max=0xAA, count=2; stat_done stays 0.
- Clear precedence:
  - Stimulus: cfg[0]=1 in the same cycle as the window-ending sample.
  - Required: outputs read 0xFF/0x00/0, no stat_done pulse, and state returns to CLEAR.
- Limit lowered mid-window:
  - Stimulus: limit=10; after 5 samples, write limit=3; feed the next sample.
  - Required: window ends with count=6 and stat_done pulses.
- Reset mid-window:
  - Stimulus: assert reset after 2 samples.
  - Required: outputs return to 0xFF/0x00/0 and the engine stays idle until cfg[0]=0.
